// File: rtl/riscv_pkg.sv
// Purpose: shared opcodes, FSM state encoding and datapath mux codes for the multicycle control unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_RT    = 7'b0110011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        ADDR,
        MEM,
        MEM_WB,
        BRANCH,
        JUMP,
        TRAP
    } state_t;

    // ALU operand A
    localparam logic [1:0] ASRC_A_PC    = 2'b00;
    localparam logic [1:0] ASRC_A_RS1   = 2'b01;
    localparam logic [1:0] ASRC_A_OLDPC = 2'b10;

    // ALU operand B
    localparam logic [1:0] ASRC_B_RS2  = 2'b00;
    localparam logic [1:0] ASRC_B_FOUR = 2'b01;
    localparam logic [1:0] ASRC_B_IMM  = 2'b10;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_RFN = 2'b10;
    localparam logic [1:0] ALUOP_IFN = 2'b11;

    // Register write-back source
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    // PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: counts consecutive memory wait cycles and flags when the allowed wait budget is used up.
// Latency: expired is registered-count based, valid in the cycle the count equals MEM_TIMEOUT.
// Backpressure: none; en/clear are sampled every cycle, clear has priority over en.
// Ports: clk, rst (sync, active-high), en (wait cycle), clear (access done / state left), expired.
module bus_timeout_counter #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Saturate rather than wrap so a disabled timeout (MEM_TIMEOUT=0) never aliases.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: multicycle RV32I control FSM sequencing one ALU and one memory port (R, OP-IMM, LW, SW, BEQ, JAL).
// Latency: BEQ/JAL 3 cycles, R/OP-IMM/SW 4, LW 5, plus one per memory wait cycle.
// Backpressure: FETCH/MEM hold mem_req/iord/mem_we until mem_ready; too long a stall traps.
// Ports: opcode/zero/mem_ready in; memory handshake, datapath mux selects/enables,
//        retire pulse and sticky fault/fault_cause out.
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter bit SUPPORT_JAL = 1'b1,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic [1:0] memtoreg,
    output logic       retire,
    output logic       fault,
    output logic [1:0] fault_cause
);

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       mem_wait;
    logic       expired;
    logic       timed_out;

    assign mem_wait  = (state_q == FETCH) || (state_q == MEM);
    // A ready in the same cycle as expiry completes the access instead of trapping.
    assign timed_out = mem_wait && !mem_ready && expired;

    bus_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (mem_wait && !mem_ready),
        .clear   (!mem_wait || mem_ready || (state_d != state_q)),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = PCSRC_ALU;
        alusrc_a = ASRC_A_PC;
        alusrc_b = ASRC_B_RS2;
        aluop    = ALUOP_ADD;
        regwrite = 1'b0;
        memtoreg = WB_ALUOUT;
        retire   = 1'b0;
        fault    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // PC <= PC + 4 through the ALU while IR loads
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    alusrc_b = ASRC_B_FOUR;
                    state_d  = DECODE;
                end else if (timed_out) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                // Speculative branch/jump target into ALUOut
                alusrc_a = ASRC_A_OLDPC;
                alusrc_b = ASRC_B_IMM;
                case (opcode)
                    OP_RT:         state_d = EXEC_R;
                    OP_OPIMM:      state_d = EXEC_I;
                    OP_LW, OP_SW:  state_d = ADDR;
                    OP_BEQ:        state_d = BRANCH;
                    OP_JAL: begin
                        if (SUPPORT_JAL) begin
                            state_d = JUMP;
                        end else begin
                            state_d = TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            EXEC_R: begin
                alusrc_a = ASRC_A_RS1;
                aluop    = ALUOP_RFN;
                state_d  = ALU_WB;
            end
            EXEC_I: begin
                alusrc_a = ASRC_A_RS1;
                alusrc_b = ASRC_B_IMM;
                aluop    = ALUOP_IFN;
                state_d  = ALU_WB;
            end
            ALU_WB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            ADDR: begin
                alusrc_a = ASRC_A_RS1;
                alusrc_b = ASRC_B_IMM;
                state_d  = MEM;
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = MEM_WB;
                    end
                end else if (timed_out) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            MEM_WB: begin
                regwrite = 1'b1;
                memtoreg = WB_MDR;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrc_a = ASRC_A_RS1;
                aluop    = ALUOP_SUB;
                pc_src   = PCSRC_ALUOUT;
                pc_write = zero;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                regwrite = 1'b1;
                memtoreg = WB_PC4;
                pc_write = 1'b1;
                pc_src   = PCSRC_ALUOUT;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign fault_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam logic [6:0] RT  = 7'h33;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] LW  = 7'h03;
    localparam logic [6:0] SW  = 7'h23;
    localparam logic [6:0] BEQ = 7'h63;
    localparam logic [6:0] JAL = 7'h6F;
    localparam int TMO = 15;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JAL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [6:0] opcode = RT;

    logic       mem_req, mem_we, iord, ir_write, pc_write, regwrite, retire, fault;
    logic [1:0] pc_src, alusrc_a, alusrc_b, aluop, memtoreg, fault_cause;

    logic       nj_req, nj_we, nj_iord, nj_irw, nj_pcw, nj_rw, nj_ret, nj_fault;
    logic [1:0] nj_pcs, nj_a, nj_b, nj_op, nj_m2r, nj_cause;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model: position within the current instruction
    bit         m_trap = 1'b0;
    logic [1:0] m_cause = 2'b00;
    int         m_step = 0;
    int         m_cls = C_R;
    int         m_wait = 0;

    logic [19:0] dut_vec;
    logic [19:0] exp_vec;

    always #5 clk = ~clk;

    multicycle_control_unit #(.SUPPORT_JAL(1'b1), .MEM_TIMEOUT(TMO), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .aluop(aluop), .regwrite(regwrite), .memtoreg(memtoreg), .retire(retire),
        .fault(fault), .fault_cause(fault_cause)
    );

    multicycle_control_unit #(.SUPPORT_JAL(1'b0), .MEM_TIMEOUT(TMO), .TO_W(4)) dut_nojal (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(nj_req), .mem_we(nj_we), .iord(nj_iord), .ir_write(nj_irw),
        .pc_write(nj_pcw), .pc_src(nj_pcs), .alusrc_a(nj_a), .alusrc_b(nj_b),
        .aluop(nj_op), .regwrite(nj_rw), .memtoreg(nj_m2r), .retire(nj_ret),
        .fault(nj_fault), .fault_cause(nj_cause)
    );

    assign dut_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a, alusrc_b,
                      aluop, regwrite, memtoreg, retire, fault, fault_cause};

    function automatic int len_of(input int cls);
        case (cls)
            C_LW:         return 5;
            C_BEQ, C_JAL: return 3;
            default:      return 4;
        endcase
    endfunction

    function automatic bit is_mem_step(input int step, input int cls);
        return (step == 0) || (step == 3 && (cls == C_LW || cls == C_SW));
    endfunction

    // Expected outputs from the instruction class, step number and live inputs
    function automatic logic [19:0] model_out();
        logic req, we, io, irw, pcw, rw, ret, flt;
        logic [1:0] pcs, a, b, op, m2r, cs;
        {req, we, io, irw, pcw, rw, ret, flt} = 8'h00;
        {pcs, a, b, op, m2r, cs} = 12'h000;
        if (m_trap) begin
            flt = 1'b1;
            cs  = m_cause;
        end else if (m_step == 0) begin
            req = 1'b1;
            if (mem_ready) begin
                irw = 1'b1; pcw = 1'b1; b = 2'b01;
            end
        end else if (m_step == 1) begin
            a = 2'b10; b = 2'b10;
        end else begin
            case (m_cls)
                C_R, C_I: begin
                    if (m_step == 2) begin
                        a = 2'b01;
                        b  = (m_cls == C_R) ? 2'b00 : 2'b10;
                        op = (m_cls == C_R) ? 2'b10 : 2'b11;
                    end else begin
                        rw = 1'b1; ret = 1'b1;
                    end
                end
                C_LW, C_SW: begin
                    if (m_step == 2) begin
                        a = 2'b01; b = 2'b10;
                    end else if (m_step == 3) begin
                        req = 1'b1; io = 1'b1;
                        we  = (m_cls == C_SW);
                        ret = (m_cls == C_SW) && mem_ready;
                    end else begin
                        rw = 1'b1; m2r = 2'b01; ret = 1'b1;
                    end
                end
                C_BEQ: begin
                    a = 2'b01; op = 2'b01; pcs = 2'b01; pcw = zero; ret = 1'b1;
                end
                default: begin
                    rw = 1'b1; m2r = 2'b10; pcw = 1'b1; pcs = 2'b01; ret = 1'b1;
                end
            endcase
        end
        return {req, we, io, irw, pcw, pcs, a, b, op, rw, m2r, ret, flt, cs};
    endfunction

    // Model advance on each active edge
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_trap = 1'b0; m_cause = 2'b00; m_step = 0; m_wait = 0;
        end else if (!m_trap) begin
            if (is_mem_step(m_step, m_cls)) begin
                if (mem_ready) begin
                    m_wait = 0;
                    if (m_step == 0)        m_step = 1;
                    else if (m_cls == C_SW) m_step = 0;
                    else                    m_step = 4;
                end else if (m_wait == TMO) begin
                    m_trap = 1'b1; m_cause = 2'b10; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else if (m_step == 1) begin
                case (opcode)
                    RT:      m_cls = C_R;
                    OPI:     m_cls = C_I;
                    LW:      m_cls = C_LW;
                    SW:      m_cls = C_SW;
                    BEQ:     m_cls = C_BEQ;
                    JAL:     m_cls = C_JAL;
                    default: begin m_trap = 1'b1; m_cause = 2'b01; end
                endcase
                m_step = 2;
            end else begin
                m_step = (m_step == len_of(m_cls) - 1) ? 0 : m_step + 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            exp_vec = model_out();
            n_chk++;
            if (dut_vec === exp_vec) n_pass++;
            else $display("FAIL outputs cyc=%0d step=%0d: dut=%05h model=%05h", cyc, m_step, dut_vec, exp_vec);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic go(input logic rdy, input logic z, input logic r);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        rst       = r;
        @(negedge clk);
    endtask

    function automatic logic [6:0] pick_op();
        int s;
        logic [6:0] v;
        s = $urandom_range(0, 15);
        v = 7'($urandom);
        if (s < 3)       return RT;
        else if (s < 6)  return OPI;
        else if (s < 8)  return LW;
        else if (s < 10) return SW;
        else if (s < 12) return BEQ;
        else if (s < 14) return JAL;
        else if (s == 14) return v;
        return 7'h7F;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit, expected finish well before 1000000");
        $fatal(1);
    end

    initial begin
        int stall;
        logic rd, rr;
        stall = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // R-type, memory always ready
        opcode = RT;
        go(1, 0, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cause", fault_cause, 0);
        chk("r_irwrite", ir_write, 1);
        go(1, 0, 0);
        go(1, 0, 0);
        chk("r_aluop", aluop, 2);
        go(1, 0, 0);
        chk("r_wb_retire", {regwrite, retire}, 2'b11);
        opcode = LW;
        go(1, 0, 0);
        chk("r_next_req", mem_req, 1);

        // LW with two wait cycles in MEM
        go(1, 0, 0);
        go(1, 0, 0);
        go(0, 0, 0);
        chk("lw_mem_req", {mem_req, iord, mem_we}, 3'b110);
        go(0, 0, 0);
        go(1, 0, 0);
        chk("lw_req_stable", {mem_req, iord, mem_we}, 3'b110);
        go(1, 0, 0);
        chk("lw_wb", {regwrite, memtoreg, retire}, 4'b1011);

        // BEQ taken then not taken
        opcode = BEQ;
        go(1, 0, 0); go(1, 0, 0); go(1, 1, 0);
        chk("beq_taken", {pc_write, pc_src, retire}, 4'b1011);
        go(1, 0, 0); go(1, 0, 0); go(1, 0, 0);
        chk("beq_not_taken", {pc_write, retire}, 2'b01);

        // JAL: jumps on the main unit, traps on the JAL-less unit
        opcode = JAL;
        go(1, 0, 0); go(1, 0, 0); go(1, 0, 0);
        chk("jal_jump", {regwrite, memtoreg, pc_write, pc_src, retire}, 7'b1101011);
        chk("nojal_trap", {nj_fault, nj_cause, nj_req}, 4'b1010);

        // Illegal opcode
        opcode = 7'h7F;
        go(1, 0, 0);
        chk("nojal_sticky", {nj_fault, nj_req}, 2'b10);
        go(1, 0, 0); go(1, 0, 0);
        chk("ill_trap", {fault, fault_cause}, 3'b101);
        for (int k = 0; k < 3; k++) begin
            go(1, 0, 0);
            chk("ill_no_req", {mem_req, fault}, 2'b01);
        end

        // Reset clears the fault; then FETCH stalls into a timeout
        go(0, 0, 1);
        opcode = RT;
        go(0, 0, 0);
        chk("rst_clears_fault", {fault, fault_cause, mem_req}, 4'b0001);
        for (int k = 1; k <= 15; k++) go(0, 0, 0);
        chk("tmo_edge", {mem_req, fault}, 2'b10);
        go(0, 0, 0);
        chk("tmo_trap", {fault, fault_cause, mem_req}, 4'b1100);

        // Ready exactly at the limit wins
        go(0, 0, 1);
        opcode = SW;
        for (int k = 0; k < 15; k++) go(0, 0, 0);
        go(1, 0, 0);
        chk("tmo_ready_wins", ir_write, 1);
        go(1, 0, 0);
        chk("no_tmo_fault", fault, 0);

        // Reset during a pending SW
        go(1, 0, 0);
        go(0, 0, 1);
        chk("sw_mem_we", {mem_req, mem_we}, 2'b11);
        go(0, 0, 0);
        chk("rst_drops_sw", {mem_req, mem_we, fault, iord}, 4'b1000);

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            if (stall > 0) begin
                stall--;
                rd = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                stall = $urandom_range(8, 20);
                rd = 1'b0;
            end else begin
                rd = ($urandom_range(0, 3) != 0);
            end
            rr = (m_trap && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
            // A fetch completing at this edge loads a fresh instruction word
            if (m_step == 0 && mem_ready && !m_trap && !rst) opcode = pick_op();
            go(rd, 1'($urandom_range(0, 1)), rr);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
